tag_responder_reader: RTL and testbench
=======================================

Name: tag_responder_reader

Overview:
- Reader side of the CAPP tag array: takes the per-cell tag vector produced by the tag register and enumerates the tagged responders one at a time, lowest index first, as binary cell addresses.
- Lets the controller read out or write back each responder serially after a parallel search.
- Sits between the tag register and the sequential controller or I/O path.
- Snapshots the tags on start, then emits one address per valid/ready handshake until every responder has been consumed.

Parameters:
num_cells, 100, number of CAPP cells (width of tag vector)
addr_bits, 7, width of emitted cell address; must satisfy 2**addr_bits >= num_cells
cnt_bits, 7, width of responder count; must satisfy 2**cnt_bits > num_cells

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
tags_in  input  num_cells  tag vector from tag array; sampled only on accepted start
start  input  1  begin enumeration; honoured only in IDLE
abort  input  1  cancel enumeration in progress
ready  input  1  downstream accepts current address
valid  output  1  addr holds a live responder
addr  output  addr_bits  index of lowest remaining responder
last  output  1  current addr is the final remaining responder
busy  output  1  state is not IDLE
some_none  output  1  snapshot contained at least one responder
resp_count  output  cnt_bits  number of responders in snapshot
done  output  1  one-cycle pulse, enumeration complete

Behaviour:
- State register: IDLE, SCAN, DONE. Internal pending register is num_cells wide.
- Reset, asynchronous on RST_N low: state=IDLE, pending=0, some_none=0, resp_count=0, done=0.
  - Consequently valid=0, last=0, busy=0, addr=0.
  - Reset mid-enumeration discards all pending responders.
- IDLE, start=1 at an edge:
  - pending <= tags_in.
  - resp_count <= popcount(tags_in).
  - some_none <= |tags_in.
  - If tags_in nonzero, state <= SCAN; otherwise state <= DONE.
- start while busy is ignored: no resnapshot, and resp_count and some_none do not change.
- SCAN, combinational outputs from registered pending:
  - valid=1.
  - addr = index of lowest set bit of pending.
  - last=1 iff exactly one bit of pending is set.
- SCAN, handshake:
  - On valid&&ready at an edge, clear the pending bit at addr.
  - If that bit was the last one, state <= DONE.
  - When ready=0, addr and valid are held stable indefinitely.
- Latency:
  - start accepted at edge t gives first valid in the cycle after edge t.
  - Sustained throughput is one address per cycle with ready held high.
- DONE:
  - done=1 and valid=0 for exactly one cycle; state <= IDLE at the next edge.
  - start is ignored in DONE; it is accepted no earlier than the following IDLE cycle.
- abort=1 at an edge in SCAN or DONE: pending <= 0, state <= IDLE, no done pulse.
  - Abort wins over a simultaneous handshake; that address counts as not consumed.
  - abort in IDLE has no effect; abort together with start in IDLE means start is ignored.
- After completion, resp_count and some_none keep the last snapshot value until the next accepted start.
- tags_in changes after the snapshot have no effect on the enumeration.
- Widths:
  - addr zero-extended cell index.
  - Cells with index >= num_cells do not exist.
  - popcount saturation is impossible by the parameter constraints.

Test Plan:
(all with num_cells=8, addr_bits=3, cnt_bits=4)
- tags_in=8'b1010_0110, start, ready=1 -> resp_count=4, some_none=1; addr sequence 1,2,5,7 on consecutive cycles; last=1 only with addr=7; done pulse the cycle after addr=7; busy low after.
- tags_in=8'b0000_0000, start -> no valid; some_none=0, resp_count=0; done pulses in the cycle after the start edge; returns to IDLE.
- tags_in=8'b1000_0001, ready=0 for 5 cycles then 1 -> addr=0, valid=1 held stable for 5 cycles; then 0, 7 emitted; tags_in changed to 8'hFF mid-scan has no effect.
- Start during SCAN with tags_in=8'hFF -> ignored; original sequence completes; resp_count unchanged.
- tags_in=8'b0011_1000, abort asserted with ready=1 while addr=4 -> next cycle IDLE, valid=0, no done pulse; a following start with 8'b0100_0000 yields addr=6 with last=1.
- RST_N low asynchronously mid-scan at addr=3 of 8'b0101_1000 -> outputs clear immediately without a clock edge; after release, IDLE with resp_count=0.

Source files
------------

// File: rtl/tag_responder_reader.sv
// tag_responder_reader: snapshots the CAPP tag vector on start and hands out
// the tagged cell addresses one per handshake, lowest index first.
//
// Handshake: valid/ready. While valid is high, addr and last are stable and
// change only after an edge where valid && ready were both high (the transfer).
// valid never drops without a transfer unless abort or RST_N intervenes.
module tag_responder_reader #(
    parameter int num_cells = 100,
    parameter int addr_bits = 7,
    parameter int cnt_bits  = 7
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [num_cells-1:0] tags_in,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 ready,
    output logic                 valid,
    output logic [addr_bits-1:0] addr,
    output logic                 last,
    output logic                 busy,
    output logic                 some_none,
    output logic [cnt_bits-1:0]  resp_count,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [num_cells-1:0] lsb_one = {{(num_cells-1){1'b0}}, 1'b1};

    state_t                state;
    logic [num_cells-1:0]  pending;
    logic [num_cells-1:0]  low_bit;
    logic [num_cells-1:0]  pending_next;
    logic [addr_bits-1:0]  low_idx;
    logic [cnt_bits-1:0]   tag_count;

    // Isolate the lowest remaining responder and the set left after consuming it.
    always_comb begin
        low_bit      = pending & (~pending + lsb_one);
        pending_next = pending & ~low_bit;
    end

    // Priority encode: index of the lowest set bit of pending (0 when empty).
    always_comb begin
        low_idx = '0;
        for (int i = num_cells - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = addr_bits'(i);
            end
        end
    end

    // Population count of the incoming tag vector, used only at snapshot time.
    always_comb begin
        tag_count = '0;
        for (int i = 0; i < num_cells; i++) begin
            tag_count = tag_count + cnt_bits'(tags_in[i]);
        end
    end

    // Outputs decode directly from the state and pending registers.
    assign valid = (state == SCAN);
    assign addr  = valid ? low_idx : '0;
    assign last  = valid && (pending_next == '0);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    // Enumeration FSM: snapshot on start, consume one responder per transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            pending    <= '0;
            some_none  <= 1'b0;
            resp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort alongside start suppresses the start
                    if (start && !abort) begin
                        pending    <= tags_in;
                        resp_count <= tag_count;
                        some_none  <= |tags_in;
                        state      <= (|tags_in) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    // abort beats a simultaneous transfer; that address is not consumed
                    if (abort) begin
                        pending <= '0;
                        state   <= IDLE;
                    end else if (ready) begin
                        pending <= pending_next;
                        if (pending_next == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // single-cycle done pulse; start here is ignored
                    pending <= '0;
                    state   <= IDLE;
                end
                default: begin
                    pending <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_responder_reader.sv
// Bench for tag_responder_reader with 8 cells: directed scenarios followed by
// random traffic, all checked against a queue-based model of the responder list.
module tb_tag_responder_reader;

    localparam int NC = 8;
    localparam int AB = 3;
    localparam int CB = 4;

    logic          CLK;
    logic          RST_N;
    logic [NC-1:0] tags_in;
    logic          start;
    logic          abort;
    logic          ready;
    logic          valid;
    logic [AB-1:0] addr;
    logic          last;
    logic          busy;
    logic          some_none;
    logic [CB-1:0] resp_count;
    logic          done;

    tag_responder_reader #(
        .num_cells (NC),
        .addr_bits (AB),
        .cnt_bits  (CB)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .tags_in    (tags_in),
        .start      (start),
        .abort      (abort),
        .ready      (ready),
        .valid      (valid),
        .addr       (addr),
        .last       (last),
        .busy       (busy),
        .some_none  (some_none),
        .resp_count (resp_count),
        .done       (done)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    // reference model: remaining responders in consumption order
    logic [AB-1:0] exp_q[$];
    logic          m_done_due = 1'b0;
    int            m_count    = 0;
    logic          m_some     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic          e_valid;
        logic [AB-1:0] e_addr;
        e_valid = (exp_q.size() > 0);
        e_addr  = e_valid ? exp_q[0] : '0;
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".addr"}, 32'(addr), 32'(e_addr));
        check({tag, ".last"}, 32'(last), 32'(exp_q.size() == 1));
        check({tag, ".busy"}, 32'(busy), 32'(e_valid || m_done_due));
        check({tag, ".done"}, 32'(done), 32'(m_done_due));
        check({tag, ".some_none"}, 32'(some_none), 32'(m_some));
        check({tag, ".resp_count"}, 32'(resp_count), 32'(m_count));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_done_due = 1'b0;
        m_count    = 0;
        m_some     = 1'b0;
    endtask

    // driver: apply inputs for one edge, advance the model, check after the edge
    task automatic step(input logic s, input logic a, input logic r,
                        input logic [NC-1:0] t, input string tag);
        start   = s;
        abort   = a;
        ready   = r;
        tags_in = t;
        if (exp_q.size() == 0 && !m_done_due) begin
            if (s && !a) begin
                for (int i = 0; i < NC; i++) begin
                    if (t[i]) exp_q.push_back(AB'(i));
                end
                m_count    = exp_q.size();
                m_some     = (exp_q.size() > 0);
                m_done_due = (exp_q.size() == 0);
            end
        end else if (m_done_due) begin
            m_done_due = 1'b0;
        end else if (a) begin
            exp_q.delete();
        end else if (r) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done_due = 1'b1;
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    // asynchronous reset between edges, checked before any clock edge
    task automatic async_reset(input string tag);
        #3;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N   = 1'b0;
        tags_in = '0;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b0;
        #12;
        check_outputs("reset");
        RST_N = 1'b1;

        // four responders with ready high; start during the done pulse is ignored
        step(1, 0, 1, 8'b1010_0110, "t1_start");
        step(0, 0, 1, 8'b1010_0110, "t1_a1");
        step(0, 0, 1, 8'b1010_0110, "t1_a2");
        step(0, 0, 1, 8'b1010_0110, "t1_a5");
        step(0, 0, 1, 8'b1010_0110, "t1_a7");
        step(1, 0, 1, 8'hFF, "t1_done_start");
        step(0, 0, 1, 8'h00, "t1_idle");

        // empty snapshot
        step(1, 0, 1, 8'h00, "t2_start");
        step(0, 0, 1, 8'h00, "t2_idle");

        // stall with ready low, tags changing mid-scan
        step(1, 0, 0, 8'b1000_0001, "t3_start");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'hFF, "t3_hold");
        step(0, 0, 1, 8'hFF, "t3_a0");
        step(0, 0, 1, 8'hFF, "t3_a7");
        step(0, 0, 1, 8'hFF, "t3_idle");

        // start while scanning is ignored
        step(1, 0, 1, 8'b0001_0100, "t4_start");
        step(1, 0, 1, 8'hFF, "t4_restart");
        step(1, 0, 1, 8'hFF, "t4_a4");
        step(0, 0, 1, 8'h00, "t4_done");

        // abort at addr=4 with ready high, then a fresh single-responder start
        step(1, 0, 1, 8'b0011_1000, "t5_start");
        step(0, 0, 1, 8'b0011_1000, "t5_a3");
        step(0, 1, 1, 8'b0011_1000, "t5_abort");
        step(1, 1, 1, 8'b0100_0000, "t5_abort_start");
        step(1, 0, 0, 8'b0100_0000, "t5_start6");
        step(0, 0, 1, 8'h00, "t5_a6");
        step(0, 0, 1, 8'h00, "t5_done");

        // asynchronous reset while addr=3 is presented
        step(1, 0, 0, 8'b0101_1000, "t6_start");
        async_reset("t6_async");
        step(0, 0, 1, 8'h00, "t6_after");

        // random traffic
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) != 0), NC'($urandom_range(0, 255)), "rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_async");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
